// File: rtl/ex_issue_ctrl_if.sv
// ID/EX/WB handshake bundle for the issue controller.
// master = pipeline side driving ID and WB, slave = the controller.
interface ex_issue_ctrl_if;
  logic       id_valid;
  logic [3:0] id_alu_op;
  logic [4:0] id_rs1_addr;
  logic [4:0] id_rs2_addr;
  logic [4:0] id_rd_addr;
  logic       id_rd_we;
  logic       id_ready;
  logic       ex_valid;
  logic [3:0] ex_alu_op;
  logic [4:0] ex_rd_addr;
  logic       ex_rd_we;
  logic       wb_valid;
  logic [4:0] wb_rd_addr;
  logic       wb_rd_we;

  modport master (
    output id_valid, id_alu_op, id_rs1_addr,
    output id_rs2_addr, id_rd_addr, id_rd_we,
    output wb_valid, wb_rd_addr, wb_rd_we,
    input  id_ready, ex_valid, ex_alu_op,
    input  ex_rd_addr, ex_rd_we
  );

  modport slave (
    input  id_valid, id_alu_op, id_rs1_addr,
    input  id_rs2_addr, id_rd_addr, id_rd_we,
    input  wb_valid, wb_rd_addr, wb_rd_we,
    output id_ready, ex_valid, ex_alu_op,
    output ex_rd_addr, ex_rd_we
  );
endinterface

// File: rtl/ex_issue_ctrl.sv
// ID->EX issue control: RAW scoreboard, credit counter, drain FSM.
// Define EX_ISSUE_WB_BYPASS_EN to let same-cycle WB release hazards/credit.
module ex_issue_ctrl #(
  parameter int MAX_PEND = 3,
  parameter int CNT_W    = 3
) (
  input  logic           clk,
  input  logic           reset_n,
  ex_issue_ctrl_if.slave bus,
  input  logic           drain_req,
  output logic           drain_done,
  output logic           err_underflow
);

  localparam logic [3:0] ADD_ALU = 4'd0;
  localparam logic [3:0] SUB_ALU = 4'd1;
  localparam logic [3:0] AND_ALU = 4'd2;
  localparam logic [3:0] OR_ALU  = 4'd3;
  localparam logic [3:0] SLL_ALU = 4'd4;
  localparam logic [3:0] SRA_ALU = 4'd5;
  localparam logic [3:0] SW_ALU  = 4'd6;
  localparam logic [3:0] LW_ALU  = 4'd7;

  localparam logic [CNT_W-1:0] MAXC = CNT_W'(MAX_PEND);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [31:0]      sb_q;
  logic [31:0]      sb_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic rs1_used;
  logic rs2_used;
  logic wb_clr;
  logic byp1;
  logic byp2;
  logic busy1;
  logic busy2;
  logic credit_ok;
  logic issue;
  logic wb_dec;

  always_comb begin
    rs1_used = bus.id_alu_op inside {
      ADD_ALU, SUB_ALU, AND_ALU, OR_ALU,
      SLL_ALU, SRA_ALU, SW_ALU, LW_ALU
    };
    rs2_used = bus.id_alu_op inside {
      ADD_ALU, SUB_ALU, AND_ALU, OR_ALU,
      SLL_ALU, SRA_ALU, SW_ALU
    };
  end

  assign wb_clr = bus.wb_valid && bus.wb_rd_we &&
                  (bus.wb_rd_addr != 5'd0);

`ifdef EX_ISSUE_WB_BYPASS_EN
  assign byp1 = wb_clr && (bus.wb_rd_addr == bus.id_rs1_addr);
  assign byp2 = wb_clr && (bus.wb_rd_addr == bus.id_rs2_addr);
  assign credit_ok = (cnt_q < MAXC) || bus.wb_valid;
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
  assign credit_ok = (cnt_q < MAXC);
`endif

  assign busy1 = rs1_used && (bus.id_rs1_addr != 5'd0) &&
                 sb_q[bus.id_rs1_addr] && !byp1;
  assign busy2 = rs2_used && (bus.id_rs2_addr != 5'd0) &&
                 sb_q[bus.id_rs2_addr] && !byp2;

  // The first cycle drain_req is seen still sits in RUN, so gate on it too
  assign issue = bus.id_valid && (state_q == RUN) && !drain_req &&
                 !busy1 && !busy2 && credit_ok;
  assign bus.id_ready = issue;

  assign wb_dec = bus.wb_valid && (cnt_q != '0);

  always_comb begin
    sb_d = sb_q;
    if (wb_clr)
      sb_d[bus.wb_rd_addr] = 1'b0;
    // Applied after the clear so a same-rd issue keeps the bit set
    if (issue && bus.id_rd_we && (bus.id_rd_addr != 5'd0))
      sb_d[bus.id_rd_addr] = 1'b1;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (issue && !wb_dec)
      cnt_d = cnt_q + CNT_W'(1);
    else if (!issue && wb_dec)
      cnt_d = cnt_q - CNT_W'(1);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:
        if (drain_req)
          state_d = DRAIN;
      DRAIN:
        if (!drain_req)
          state_d = RUN;
        else if ((cnt_q == '0) && (sb_q == '0))
          state_d = DONE;
      DONE:
        if (!drain_req)
          state_d = RUN;
      default:
        state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= RUN;
      sb_q          <= '0;
      cnt_q         <= '0;
      drain_done    <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      state_q    <= state_d;
      sb_q       <= sb_d;
      cnt_q      <= cnt_d;
      drain_done <= (state_d == DONE);
      if (bus.wb_valid && (cnt_q == '0))
        err_underflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.ex_valid   <= 1'b0;
      bus.ex_alu_op  <= '0;
      bus.ex_rd_addr <= '0;
      bus.ex_rd_we   <= 1'b0;
    end else begin
      bus.ex_valid <= issue;
      if (issue) begin
        bus.ex_alu_op  <= bus.id_alu_op;
        bus.ex_rd_addr <= bus.id_rd_addr;
        bus.ex_rd_we   <= bus.id_rd_we;
      end
    end
  end

endmodule

// File: tb/tb_ex_issue_ctrl.sv
// Bench for ex_issue_ctrl: directed scenarios plus random traffic,
// all checked against a register/queue level reference model.
module tb_ex_issue_ctrl;

  localparam int MAX_PEND = 3;
`ifdef EX_ISSUE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam logic [3:0] ADD = 4'd0;
  localparam logic [3:0] SUB = 4'd1;
  localparam logic [3:0] AND_ = 4'd2;
  localparam logic [3:0] OR_ = 4'd3;
  localparam logic [3:0] SLL = 4'd4;
  localparam logic [3:0] SRA = 4'd5;
  localparam logic [3:0] SW = 4'd6;
  localparam logic [3:0] LW = 4'd7;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic drain_req = 1'b0;
  logic drain_done;
  logic err_underflow;

  ex_issue_ctrl_if bus ();

  ex_issue_ctrl #(.MAX_PEND(MAX_PEND), .CNT_W(3)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus.slave),
    .drain_req    (drain_req),
    .drain_done   (drain_done),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  bit [31:0]   m_sb;
  int          m_cnt;
  int          m_mode;    // 0 run, 1 draining, 2 drained
  bit          m_err;
  bit          e_v;
  logic [3:0]  e_op;
  logic [4:0]  e_rd;
  logic        e_we;
  logic [5:0]  q[$];      // {we, rd} of instructions in flight

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit reads1(logic [3:0] op);
    return op inside {ADD, SUB, AND_, OR_, SLL, SRA, SW, LW};
  endfunction

  function automatic bit reads2(logic [3:0] op);
    return op inside {ADD, SUB, AND_, OR_, SLL, SRA, SW};
  endfunction

  function automatic bit blocked(bit used, logic [4:0] r);
    bit released;
    released = BYP && bus.wb_valid && bus.wb_rd_we && (bus.wb_rd_addr == r);
    return used && (r != 0) && m_sb[r] && !released;
  endfunction

  task automatic model_clear();
    m_sb = '0; m_cnt = 0; m_mode = 0; m_err = 0;
    e_v = 0; e_op = '0; e_rd = '0; e_we = 0;
    q.delete();
  endtask

  task automatic set_id(bit v, logic [3:0] op, logic [4:0] a,
                        logic [4:0] b, logic [4:0] rd, bit we);
    bus.id_valid = v; bus.id_alu_op = op;
    bus.id_rs1_addr = a; bus.id_rs2_addr = b;
    bus.id_rd_addr = rd; bus.id_rd_we = we;
  endtask

  task automatic set_wb(bit v, logic [4:0] rd, bit we);
    bus.wb_valid = v; bus.wb_rd_addr = rd; bus.wb_rd_we = we;
  endtask

  task automatic retire_head();
    if (q.size() > 0) set_wb(1'b1, q[0][4:0], q[0][5]);
    else set_wb(1'b0, 5'd0, 1'b0);
  endtask

  task automatic check_regs();
    chk("ex_valid", bus.ex_valid, e_v);
    chk("ex_alu_op", bus.ex_alu_op, e_op);
    chk("ex_rd_addr", bus.ex_rd_addr, e_rd);
    chk("ex_rd_we", bus.ex_rd_we, e_we);
    chk("drain_done", drain_done, m_mode == 2);
    chk("err_underflow", err_underflow, m_err);
  endtask

  // One clock: inputs are already driven; check id_ready, advance model
  task automatic cycle();
    bit rdy;
    int nmode;
    @(negedge clk);
    rdy = bus.id_valid && (m_mode == 0) && !drain_req &&
          !blocked(reads1(bus.id_alu_op), bus.id_rs1_addr) &&
          !blocked(reads2(bus.id_alu_op), bus.id_rs2_addr) &&
          ((m_cnt < MAX_PEND) || (BYP && bus.wb_valid));
    chk("id_ready", bus.id_ready, rdy);
    nmode = m_mode;
    if (!drain_req) nmode = 0;
    else if (m_mode == 0) nmode = 1;
    else if (m_mode == 1 && m_cnt == 0 && m_sb == 0) nmode = 2;
    m_mode = nmode;
    if (bus.wb_valid) begin
      if (m_cnt == 0) m_err = 1;
      else begin
        m_cnt--;
        void'(q.pop_front());
      end
      if (bus.wb_rd_we && bus.wb_rd_addr != 0) m_sb[bus.wb_rd_addr] = 0;
    end
    e_v = rdy;
    if (rdy) begin
      m_cnt++;
      q.push_back({bus.id_rd_we, bus.id_rd_addr});
      if (bus.id_rd_we && bus.id_rd_addr != 0) m_sb[bus.id_rd_addr] = 1;
      e_op = bus.id_alu_op; e_rd = bus.id_rd_addr; e_we = bus.id_rd_we;
    end
    @(posedge clk);
    #1;
    check_regs();
  endtask

  task automatic idle();
    set_id(1'b0, ADD, 5'd0, 5'd0, 5'd0, 1'b0);
    set_wb(1'b0, 5'd0, 1'b0);
  endtask

  task automatic retire_all();
    idle();
    for (int i = 0; i < 8 && q.size() > 0; i++) begin
      retire_head();
      cycle();
    end
    idle();
    chk("retired_all", q.size(), 0);
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    model_clear();
    check_regs();
    idle();
    drain_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_regs();
  endtask

  initial begin
    model_clear();
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_regs();

    // in-flight state discarded by reset
    set_id(1'b1, ADD, 5'd1, 5'd2, 5'd5, 1'b1); cycle();
    set_id(1'b1, ADD, 5'd1, 5'd2, 5'd6, 1'b1); cycle();
    chk("pre_reset_cnt", m_cnt, 2);
    mid_reset();
    set_id(1'b1, SUB, 5'd5, 5'd6, 5'd9, 1'b1); cycle();
    chk("x5_free_after_reset", e_v, 1);
    retire_all();

    // RAW stall on x5 until its WB
    set_id(1'b1, ADD, 5'd1, 5'd2, 5'd5, 1'b1); cycle();
    set_id(1'b1, SUB, 5'd5, 5'd0, 5'd0, 1'b0); cycle(); cycle();
    chk("raw_stall", e_v, 0);
    set_wb(1'b1, 5'd5, 1'b1); cycle();
    chk("raw_same_cycle", e_v, BYP);
    set_wb(1'b0, 5'd0, 1'b0); cycle();
    retire_all();

    // x0 never busy
    set_id(1'b1, LW, 5'd0, 5'd0, 5'd0, 1'b1); cycle();
    set_id(1'b1, SW, 5'd0, 5'd0, 5'd0, 1'b0); cycle();
    chk("x0_back_to_back", e_v, 1);
    retire_all();

    // credit limit
    for (int i = 1; i <= 4; i++) begin
      set_id(1'b1, ADD, 5'd0, 5'd0, 5'(i), 1'b1);
      cycle();
      if (i == 4) chk("fourth_stalls", e_v, 0);
    end
    cycle();
    retire_head(); cycle();
    chk("credit_release", e_v, BYP);
    set_wb(1'b0, 5'd0, 1'b0); cycle();
    chk("cnt_full", m_cnt, 3);
    retire_all();

    // issue and WB of x7 together: x7 stays busy
    set_id(1'b1, ADD, 5'd0, 5'd0, 5'd7, 1'b1); cycle();
    set_id(1'b1, ADD, 5'd0, 5'd0, 5'd7, 1'b1);
    set_wb(1'b1, 5'd7, 1'b1); cycle();
    set_wb(1'b0, 5'd0, 1'b0);
    set_id(1'b1, SUB, 5'd7, 5'd0, 5'd0, 1'b0); cycle();
    chk("x7_still_busy", e_v, 0);
    chk("cnt_unchanged", m_cnt, 1);
    retire_all();

    // drain
    set_id(1'b1, ADD, 5'd0, 5'd0, 5'd1, 1'b1); cycle();
    set_id(1'b1, ADD, 5'd0, 5'd0, 5'd2, 1'b1); cycle();
    drain_req = 1'b1;
    set_id(1'b1, ADD, 5'd0, 5'd0, 5'd3, 1'b1); cycle();
    set_id(1'b0, ADD, 5'd0, 5'd0, 5'd0, 1'b0);
    for (int i = 0; i < 10 && !(m_mode == 2); i++) begin
      retire_head();
      cycle();
    end
    set_wb(1'b0, 5'd0, 1'b0);
    chk("drain_reached", drain_done, 1);
    drain_req = 1'b0; cycle();
    chk("drain_released", drain_done, 0);
    set_wb(1'b1, 5'd0, 1'b0); cycle();
    chk("underflow_sticky", err_underflow, 1);
    idle(); cycle();

    mid_reset();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 19) == 0) drain_req = ~drain_req;
      set_id($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      if (q.size() > 0 && $urandom_range(0, 2) != 0) retire_head();
      else set_wb(1'b0, 5'd0, 1'b0);
      cycle();
    end
    drain_req = 1'b0;
    retire_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ex_issue_ctrl.md
Name: ex_issue_ctrl

Overview:
- Issue controller between the ID and EX stages; decides each cycle whether the decoded instruction may enter the ALU/EX stage.
- Keeps a 32-entry register scoreboard to block RAW hazards and an in-flight credit counter to bound outstanding instructions.
- Supports a drain request that holds issue until the pipeline is empty.
- Registers the accepted instruction's control fields toward EX.

Parameters:
- MAX_PEND, 3, maximum instructions issued but not yet retired at WB (1..7).
- CNT_W, 3, width of the in-flight counter; must hold MAX_PEND.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- id_valid  input  1  ID presents an instruction
- id_alu_op  input  4  ALU opcode (`ADD_ALU`..`LW_ALU` from riscv_define_all.v)
- id_rs1_addr  input  5  source register 1
- id_rs2_addr  input  5  source register 2
- id_rd_addr  input  5  destination register
- id_rd_we  input  1  destination write enable
- id_ready  output  1  instruction accepted this cycle (combinational)
- ex_valid  output  1  registered issue strobe to EX
- ex_alu_op  output  4  registered opcode to EX
- ex_rd_addr  output  5  registered rd to EX
- ex_rd_we  output  1  registered write enable to EX
- wb_valid  input  1  one instruction retires this cycle
- wb_rd_addr  input  5  retiring destination
- wb_rd_we  input  1  retiring instruction wrote rd
- drain_req  input  1  level request to empty the pipeline
- drain_done  output  1  drain reached; pipeline empty
- err_underflow  output  1  sticky: wb_valid seen with zero in flight

Behaviour:
- Reset: all outputs 0, scoreboard all clear, counter 0, FSM in RUN. Reset is asynchronous and may assert mid-operation; every in-flight record is discarded.
- Source use:
  - rs1 is read by all eight opcodes.
  - rs2 is read by ADD, SUB, AND, OR, SLL, SRA and SW only.
  - Any other opcode reads no sources and is issued as a bubble-safe no-op.
- Hazard: a source is busy if it is used, its address is non-zero, and its scoreboard bit is set. Register x0 is never busy.
- Credit: issue is blocked when cnt == MAX_PEND.
- id_ready = id_valid && state==RUN && no busy source && cnt<MAX_PEND.
- Issue pipeline:
  - ex_* fields load on the id_ready cycle, one-cycle latency.
  - ex_valid=0 on any non-issue cycle; ex_* fields then hold their last values.
- Scoreboard:
  - On issue with id_rd_we=1 and rd!=0, set bit rd.
  - On wb_valid with wb_rd_we=1 and rd!=0, clear bit rd.
  - If set and clear hit the same rd in the same cycle, set wins.
- Counter:
  - +1 on issue, -1 on wb_valid; both in the same cycle leaves it unchanged.
  - wb_valid at cnt==0 leaves cnt at 0 and sets err_underflow; it is cleared only by reset.
- FSM:
  - RUN: normal issue. On drain_req=1, go to DRAIN; no issue in the cycle drain_req is first sampled.
  - DRAIN: id_ready=0. When cnt==0 and the scoreboard is all clear, go to DONE.
  - DONE: drain_done=1, registered. Return to RUN when drain_req=0, and drain_done drops in the same transition.
  - If drain_req drops while in DRAIN, return to RUN immediately.
- Hazard checks use the registered scoreboard. A WB clearing in the same cycle takes effect the next cycle (see the optional feature).

Optional Feature:
- Macro: EX_ISSUE_WB_BYPASS_EN.
- Defined: a source whose bit is being cleared by wb_valid/wb_rd_we/wb_rd_addr in the current cycle is treated as not busy, so issue proceeds in that same cycle. Credit is also bypassed: cnt==MAX_PEND with wb_valid=1 allows issue.
- Undefined: no bypass; a dependent instruction issues one cycle after the WB clear.

Test Plan:
- Reset with reset_n low mid-stream (cnt=2, bit x5 set) -> next cycle cnt=0, scoreboard clear, ex_valid=0, drain_done=0, err_underflow=0.
- Issue ADD rd=x5, then SUB rs1=x5 -> SUB stalls (id_ready=0) until WB of x5. Without bypass, SUB issues the cycle after wb_valid; with EX_ISSUE_WB_BYPASS_EN, it issues in the same cycle.
- LW rs1=x0 rd=x0, then SW rs2=x0 -> both issue back-to-back; x0 is never marked busy.
- Four independent ADDs with MAX_PEND=3 and no WB -> three issue on consecutive cycles, the fourth stalls; one wb_valid releases it, and cnt stays 3.
- Issue + WB in the same cycle with rd=x7 for both -> x7 remains busy afterward; cnt unchanged.
- drain_req=1 with cnt=2 -> id_ready=0; after two wb_valid pulses, drain_done=1. Deassert drain_req -> RUN, drain_done=0. A spurious wb_valid afterward sets err_underflow=1.
